pwm_voice_mixer: RTL and testbench
==================================

// Module: pwm_voice_mixer
// PURPOSE
//  Downstream audio stage of the synth core. Consumes the eight 16-bit pwm_regN voice
//  registers written by firmware and runs eight square-wave tone oscillators from them.
//  Each oscillator is gated by a 4-bit volume; the voices are summed, and the sum drives
//  a glitch-free 8-bit PWM DAC whose 1-bit output goes to the board's audio filter.
// PARAMETERS
//  CLK_DIV   50   clk cycles per tone tick, >=2; sets tone resolution (tick = CLK_DIV clks)
//  PWM_BITS  8    PWM frame counter width; frame = 2**PWM_BITS clks; must be >=7 (mix max 120)
// PORTS
//  clk            in   1   system clock
//  rst            in   1   reset: synchronous, active-high
//  pwm_reg0..7    in   16  voice N control: [15:12] volume V (0..15), [11:0] half-period P in ticks
//  audio_out      out  1   registered PWM DAC output
//  sample_strobe  out  1   1-clk pulse when a new duty value is loaded (PWM frame start)
//  mix_level      out  8   registered voice sum, 0..120 (debug/observe)
//  voice_state    out  8   bit N = current square level of voice N
// BEHAVIOUR
//  Reset (rst=1 at posedge): prescaler, all voice counters/shadows/squares, mix_level, duty,
//   pwm counter, audio_out, sample_strobe all cleared to 0. Reset mid-frame or mid-tone
//   behaves identically; rst dominates every other event in the same cycle.
//  Prescaler: div_cnt counts 0..CLK_DIV-1, wraps to 0; tick = (div_cnt==CLK_DIV-1), 1 clk wide.
//  Voice N (state: shadow reg sh[15:0], cnt[11:0], sq), updates only on tick:
//   - sh.P==0 (IDLE): sq<=0, cnt<=0, sh<=pwm_regN (sample every tick).
//   - sh.P!=0, cnt==0 (RELOAD): sh<=pwm_regN; if new P==0 then sq<=0 (go IDLE),
//     else sq<=~sq, cnt<=new P-1.
//   - sh.P!=0, cnt!=0 (COUNT): cnt<=cnt-1.
//   - Result: sq toggles every P ticks (period 2*P*CLK_DIV clks). Register writes take
//     effect only at RELOAD (never mid half-period); from IDLE, first sq rise occurs on
//     the 2nd tick after pwm_regN.P becomes nonzero. P=1 toggles every tick.
//   - Volume change also latched only at RELOAD (via sh).
//  Mixer: mix_level <= sum over N of (sq_N ? sh_N.V : 0), registered every clk; 1 clk behind sq.
//   Sum is 7-bit unsigned (max 8*15=120), zero-extended to 8; no saturation needed.
//  PWM DAC: pwm_cnt (PWM_BITS) free-runs +1 every clk, wraps 2**PWM_BITS-1 -> 0.
//   When pwm_cnt==all-ones: duty<=mix_level, sample_strobe<=1 next cycle (else 0).
//   audio_out <= (pwm_cnt < duty), registered; duty constant for a whole frame, so
//   exactly duty high clks per frame; duty 0 -> audio_out constant 0.
//  voice_state = {sq_7..sq_0}, direct from flops.
// TESTING
//  1 rst then all pwm_reg=0 -> audio_out=0, mix_level=0, sample_strobe every 256 clks.
//  2 CLK_DIV=4, pwm_reg0=16'hF003 -> voice_state[0] toggles every 12 clks, mix_level
//    alternates 0/15, frames loaded with duty 15 give exactly 15 high clks of 256.
//  3 all regs 16'hF001 released together -> all sq in phase, mix_level 120 max, then 0.
//  4 pwm_reg0 P 3->7 mid half-period -> current half-period still 3 ticks, next is 7.
//  5 pwm_reg0 P set 0 while sq=1 -> sq drops at next RELOAD and stays 0; P back to 2
//    -> sq rises on 2nd tick afterwards.
//  6 rst pulsed mid-frame with voices active -> next clk all outputs 0, prescaler and
//    pwm_cnt restart from 0; sample_strobe first fires 256 clks later.

Source files
------------

// File: rtl/pwm_voice_mixer.sv
// Eight-voice square-wave tone mixer feeding a glitch-free PWM DAC.
// Each voice latches its register only at a half-period boundary, so tones never glitch mid-cycle.
module pwm_voice (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic [15:0] reg_val,
  output logic [15:0] sh,
  output logic        sq
);
  logic [11:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
      sq  <= 1'b0;
    end else if (tick) begin
      if (sh[11:0] == 12'd0) begin
        sq  <= 1'b0;
        cnt <= '0;
        sh  <= reg_val;
      end else if (cnt == 12'd0) begin
        // Half-period boundary: the only point where new period/volume take effect
        sh <= reg_val;
        if (reg_val[11:0] == 12'd0) begin
          sq <= 1'b0;
        end else begin
          sq  <= ~sq;
          cnt <= reg_val[11:0] - 12'd1;
        end
      end else begin
        cnt <= cnt - 12'd1;
      end
    end
  end
endmodule

module pwm_voice_mixer #(
  parameter int CLK_DIV  = 50,
  parameter int PWM_BITS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] pwm_reg0,
  input  logic [15:0] pwm_reg1,
  input  logic [15:0] pwm_reg2,
  input  logic [15:0] pwm_reg3,
  input  logic [15:0] pwm_reg4,
  input  logic [15:0] pwm_reg5,
  input  logic [15:0] pwm_reg6,
  input  logic [15:0] pwm_reg7,
  output logic        audio_out,
  output logic        sample_strobe,
  output logic [7:0]  mix_level,
  output logic [7:0]  voice_state
);
  localparam int NUM_VOICES = 8;
  localparam int DIV_W      = $clog2(CLK_DIV);

  logic [DIV_W-1:0]                 div_cnt;
  logic                             tick;
  logic [NUM_VOICES-1:0][15:0]      regs;
  logic [NUM_VOICES-1:0][15:0]      sh;
  logic [7:0]                       mix_sum;
  logic [PWM_BITS-1:0]              pwm_cnt;
  logic [PWM_BITS-1:0]              duty;

  assign regs = {pwm_reg7, pwm_reg6, pwm_reg5, pwm_reg4,
                 pwm_reg3, pwm_reg2, pwm_reg1, pwm_reg0};
  assign tick = (div_cnt == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst)       div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
    pwm_voice u_voice (
      .clk     (clk),
      .rst     (rst),
      .tick    (tick),
      .reg_val (regs[gi]),
      .sh      (sh[gi]),
      .sq      (voice_state[gi])
    );
  end

  always_comb begin
    mix_sum = '0;
    for (int i = 0; i < NUM_VOICES; i++)
      if (voice_state[i]) mix_sum = mix_sum + {4'd0, sh[i][15:12]};
  end

  // Duty only changes at the frame wrap, so each frame emits exactly duty high clocks
  always_ff @(posedge clk) begin
    if (rst) begin
      mix_level     <= '0;
      pwm_cnt       <= '0;
      duty          <= '0;
      sample_strobe <= 1'b0;
      audio_out     <= 1'b0;
    end else begin
      mix_level     <= mix_sum;
      pwm_cnt       <= pwm_cnt + PWM_BITS'(1);
      sample_strobe <= (pwm_cnt == '1);
      if (pwm_cnt == '1) duty <= PWM_BITS'(mix_level);
      audio_out     <= (pwm_cnt < duty);
    end
  end
endmodule

// File: tb/tb_pwm_voice_mixer.sv
// Directed bench for pwm_voice_mixer: closed-form timing model per scenario, frame-duty scoreboard.
module tb_pwm_voice_mixer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] r [8];
  logic        audio_out, sample_strobe;
  logic [7:0]  mix_level, voice_state;

  int errors = 0;
  int checks = 0;
  int k, hi;

  typedef struct { string tag; int exp; } sb_t;
  sb_t sbq[$];

  pwm_voice_mixer #(.CLK_DIV(4), .PWM_BITS(8)) dut (
    .clk(clk), .rst(rst),
    .pwm_reg0(r[0]), .pwm_reg1(r[1]), .pwm_reg2(r[2]), .pwm_reg3(r[3]),
    .pwm_reg4(r[4]), .pwm_reg5(r[5]), .pwm_reg6(r[6]), .pwm_reg7(r[7]),
    .audio_out(audio_out), .sample_strobe(sample_strobe),
    .mix_level(mix_level), .voice_state(voice_state)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s k=%0d: got %0h expected %0h", tag, k, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Expected square levels k clocks after reset release (ticks land on k = 4, 8, 12, ...)
  function automatic logic [7:0] exp_sq(int mode, int kk);
    case (mode)
      1: return {7'd0, (kk >= 8 && (kk - 8) % 24 < 12)};
      2: return (kk >= 8 && (kk - 8) % 8 < 4) ? 8'hFF : 8'h00;
      3: return {7'd0, (kk >= 8 && kk < 20) || (kk >= 48 && (kk - 48) % 56 < 28)};
      4: return {7'd0, (kk >= 8 && kk < 20) || (kk >= 48 && (kk - 48) % 16 < 8)};
      default: return 8'h00;
    endcase
  endfunction

  function automatic int exp_mix(int mode, int kk);
    if (kk == 0) return 0;
    return $countones(exp_sq(mode, kk - 1)) * 15;
  endfunction

  task automatic run(int mode, int n);
    sb_t e;
    sbq.delete();
    hi = 0;
    k  = 0;
    chk("reset_voice_state", voice_state, 16'd0);
    chk("reset_mix_level", mix_level, 16'd0);
    chk("reset_strobe", sample_strobe, 16'd0);
    chk("reset_audio", audio_out, 16'd0);
    sbq.push_back('{"frame_high_clks", 0});
    for (int i = 1; i <= n; i++) begin
      if (mode == 3 && k == 10) r[0] = 16'hF007;
      if (mode == 4 && k == 10) r[0] = 16'hF000;
      if (mode == 4 && k == 40) r[0] = 16'hF002;
      cyc();
      k++;
      chk("voice_state", voice_state, exp_sq(mode, k));
      chk("mix_level", mix_level, exp_mix(mode, k));
      chk("sample_strobe", sample_strobe, (k % 256 == 0));
      hi += int'(audio_out);
      if (k % 256 == 0) begin
        e = sbq.pop_front();
        chk(e.tag, hi, e.exp);
        hi = 0;
        sbq.push_back('{"frame_high_clks", exp_mix(mode, k - 1)});
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;

    // All voices idle: silence, strobe every frame
    do_reset();
    run(0, 520);

    // Single voice, P=3, full volume: duty-15 frames at k=256 and k=1024
    r[0] = 16'hF003;
    do_reset();
    run(1, 1100);

    // All voices P=1 in phase: mix swings 0 <-> 120
    for (int i = 0; i < 8; i++) r[i] = 16'hF001;
    do_reset();
    run(2, 600);

    // Period change mid half-period takes effect only at the next boundary
    for (int i = 0; i < 8; i++) r[i] = 16'h0000;
    r[0] = 16'hF003;
    do_reset();
    run(3, 300);

    // P -> 0 while high, then back to 2
    r[0] = 16'hF003;
    do_reset();
    run(4, 300);

    // Reset mid-frame while voice high and audio high, then clean restart
    r[0] = 16'hF003;
    do_reset();
    run(1, 258);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    run(1, 520);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
